alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1, upstream operation valid.
REQ-004 SHALL have port in_ready, output, 1, stage can accept an operation this cycle.
REQ-005 SHALL have port op, input, 4, opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 MUL, 12-15 illegal.
REQ-006 SHALL have port A, input, 32, first operand, or shift source for shift ops.
REQ-007 SHALL have port B, input, 32, second operand, or shift amount for shift ops.
REQ-008 SHALL have port out_valid, output, 1, result register holds an undelivered result.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-010 SHALL have port result, output, 32, registered result.
REQ-011 SHALL have port zero, output, 1, registered (result == 0).
REQ-012 SHALL have port illegal, output, 1, registered flag: the delivered op was 12-15.

Function
REQ-013 SHALL transfer input when in_valid && in_ready at a rising edge, and output when out_valid && out_ready at a rising edge.
REQ-014 SHALL implement FSM states IDLE and MUL_BUSY; in_ready = (state==IDLE) && (!out_valid || out_ready), combinational.
REQ-015 SHALL, for ops 0-10 and 12-15 accepted at edge k, register result/zero/illegal and set out_valid at edge k (visible cycle k+1); state stays IDLE.
REQ-016 SHALL, for MUL accepted at edge k, latch A, B, clear a 6-bit iteration counter and 32-bit accumulator, and enter MUL_BUSY.
REQ-017 SHALL in MUL_BUSY perform one shift-add iteration per cycle; on the 32nd iteration (edge k+32) load low 32 bits of A*B (unsigned, wrap modulo 2^32) into result, set out_valid, and return to IDLE.
REQ-018 SHALL clear out_valid on an output transfer unless a new result is loaded at the same edge, in which case out_valid stays 1 with the new result (back-to-back, no bubble).
REQ-019 SHALL hold result, zero, illegal and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL compute ADD/SUB modulo 2^32, with no overflow trap.
REQ-021 SHALL compute SLT as signed compare and SLTU as unsigned compare, with result 32'd1 or 32'd0.
REQ-022 SHALL use full 32-bit B for shifts: B >= 32 gives 0 for SLL/SRL and 32'hFFFFFFFF if A[31] else 0 for SRA; otherwise shift by B[4:0], SRA sign-filling.
REQ-023 SHALL produce result 0, zero=1, illegal=1 for ops 12-15; illegal=0 for every other op.
REQ-024 SHALL ignore in_valid while in_ready=0, with no state change.
REQ-025 SHALL, in MUL_BUSY, keep a previously loaded undelivered result valid and deliverable.

Reset
REQ-026 SHALL, on rst_n low, immediately force state=IDLE, out_valid=0, result=0, zero=0, illegal=0, counter=0, accumulator=0, independent of clk.
REQ-027 SHALL abort any in-progress MUL on reset; no result from it appears after rst_n deasserts.
REQ-028 SHALL assert in_ready=1 in the first cycle after rst_n deasserts, provided in_valid is ignored for that cycle's semantics.

Verification
REQ-029 SRA shift bounds: A=32'h80000010, B=4 -> 32'hF8000001; B=32 -> 32'hFFFFFFFF; B=33 with A=32'h7FFFFFFF -> 0, zero=1.
REQ-030 MUL timing: op=11, A=32'h0001_0003, B=32'h0001_0005 accepted at edge k -> in_ready=0 for edges k+1..k+31; out_valid rises at edge k+32 with result 32'h0008_000F.
REQ-031 Backpressure: ADD 5+7 accepted, out_ready=0 for 4 cycles -> result=12 held stable and in_ready=0; release out_ready with in_valid high (SUB 3-5) -> same-edge handoff, next result 32'hFFFFFFFE.
REQ-032 Streaming: 8 back-to-back single-cycle ops with out_ready=1 -> 8 results in order on consecutive cycles, no bubbles.
REQ-033 Illegal/compare: op=13 -> result 0, illegal=1, zero=1; SLT A=-1,B=1 -> 1; SLTU A=32'hFFFFFFFF,B=1 -> 0.
REQ-034 Reset mid-MUL: assert rst_n=0 asynchronously at cycle 10 of MUL -> out_valid=0 immediately; after release, no MUL result appears and in_ready=1.

Source files
------------

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - single-issue ALU execute stage with multi-cycle shift-add multiplier
//
// Purpose: accepts one ALU operation per cycle via a valid/ready handshake and
// presents a registered result (plus zero/illegal flags) to a valid/ready
// consumer. MUL (op 11) runs a 32-iteration shift-add sequence and blocks new
// input while busy; every other op completes in one cycle.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - upstream op valid
//   in_ready   - stage can accept an op this cycle (combinational)
//   op         - opcode (0 ADD .. 11 MUL, 12-15 illegal)
//   A, B       - operands (A = shift source, B = shift amount for shifts)
//   out_valid  - result register holds an undelivered result
//   out_ready  - downstream accepts the result
//   result     - registered result
//   zero       - registered (result == 0)
//   illegal    - registered flag, delivered op was 12-15

module alu_exec_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_out_valid;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_illegal;

    logic [5:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_alu_load;
    logic        w_mul_start;
    logic        w_mul_done;
    logic        w_out_xfer;
    logic [31:0] w_acc_next;
    logic [31:0] w_alu_res;
    logic        w_alu_ill;
    logic        w_shift_big;
    logic [4:0]  w_shamt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_mul_start) w_state_next = ST_MUL_BUSY;
            ST_MUL_BUSY: if (w_mul_done)  w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
        // The 32nd iteration is the one executed while the counter reads 31.
        w_mul_done = (r_state == ST_MUL_BUSY) && (r_cnt == 6'd31);
    end

    assign w_accept    = in_valid && w_in_ready;
    assign w_mul_start = w_accept && (op == OP_MUL);
    assign w_alu_load  = w_accept && (op != OP_MUL);
    assign w_out_xfer  = r_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    // Any set bit above bit 4 means the shift amount is 32 or more.
    assign w_shift_big = |B[31:5];
    assign w_shamt     = B[4:0];
    assign w_alu_ill   = op[3] & op[2];

    always_comb begin
        w_alu_res = 32'd0;
        case (op)
            OP_ADD:  w_alu_res = A + B;
            OP_SUB:  w_alu_res = A - B;
            OP_AND:  w_alu_res = A & B;
            OP_OR:   w_alu_res = A | B;
            OP_XOR:  w_alu_res = A ^ B;
            OP_NOR:  w_alu_res = ~(A | B);
            OP_SLL:  w_alu_res = w_shift_big ? 32'd0 : (A << w_shamt);
            OP_SRL:  w_alu_res = w_shift_big ? 32'd0 : (A >> w_shamt);
            OP_SRA:  w_alu_res = w_shift_big ? {32{A[31]}} : 32'($signed(A) >>> w_shamt);
            OP_SLT:  w_alu_res = {31'd0, ($signed(A) < $signed(B))};
            OP_SLTU: w_alu_res = {31'd0, (A < B)};
            default: w_alu_res = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier: multiplicand shifts left, multiplier shifts
    // right, one partial product folded in per cycle.
    // ------------------------------------------------------------------
    assign w_acc_next = r_acc + (r_mul_b[0] ? r_mul_a : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 6'd0;
            r_acc   <= 32'd0;
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
        end else if (w_mul_start) begin
            r_cnt   <= 6'd0;
            r_acc   <= 32'd0;
            r_mul_a <= A;
            r_mul_b <= B;
        end else if (r_state == ST_MUL_BUSY) begin
            r_cnt   <= r_cnt + 6'd1;
            r_acc   <= w_acc_next;
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
        end
    end

    // ------------------------------------------------------------------
    // Result register. A MUL is only accepted when the slot is free or
    // draining that same edge, so out_valid is always 0 while busy and
    // the MUL completion never overwrites an undelivered result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_alu_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == 32'd0);
            r_illegal   <= w_alu_ill;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == 32'd0);
            r_illegal   <= 1'b0;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage

module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the plain arithmetic meaning of each opcode.
    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (o)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~(a | b);
            4'd6:    r = a << b;
            4'd7:    r = a >> b;
            4'd8:    r = $signed(a) >>> b;
            4'd9:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10:   r = (a < b) ? 32'd1 : 32'd0;
            4'd11:   r = a * b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: one output slot plus a MUL countdown.
    // ------------------------------------------------------------------
    int          m_busy = 0;
    logic        m_ov   = 1'b0;
    logic [31:0] m_res  = 32'd0;
    logic        m_ill  = 1'b0;
    logic [31:0] m_mul  = 32'd0;
    logic        m_ir;
    logic        m_acc;

    assign m_ir  = (m_busy == 0) && (!m_ov || out_ready);
    assign m_acc = in_valid && m_ir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_ov   <= 1'b0;
            m_res  <= 32'd0;
            m_ill  <= 1'b0;
        end else if (m_busy != 0) begin
            m_busy <= m_busy - 1;
            if (m_ov && out_ready) m_ov <= 1'b0;
            if (m_busy == 1) begin
                m_ov  <= 1'b1;
                m_res <= m_mul;
                m_ill <= 1'b0;
            end
        end else begin
            if (m_ov && out_ready) m_ov <= 1'b0;
            if (m_acc) begin
                if (op == 4'd11) begin
                    m_busy <= 32;
                    m_mul  <= A * B;
                end else begin
                    m_ov  <= 1'b1;
                    m_res <= ref_alu(op, A, B);
                    m_ill <= (op >= 4'd12);
                end
            end
        end
    end

    // Compare process: mid-cycle, inputs and outputs settled.
    always @(negedge clk) begin
        chk("in_ready", in_ready, m_ir);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("result", result, m_res);
            chk("zero", zero, (m_res == 32'd0));
            chk("illegal", illegal, m_ill);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send1(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic ei);
        in_valid  = 1'b1;
        op        = o;
        A         = a;
        B         = b;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({name, "_out_valid"}, out_valid, 1);
        chk({name, "_result"}, result, er);
        chk({name, "_zero"}, zero, ez);
        chk({name, "_illegal"}, illegal, ei);
    endtask

    logic [31:0] exp_stream [8];
    int          n_bad;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'd0;
        A         = 32'd0;
        B         = 32'd0;
        out_ready = 1'b1;

        // Model pinned against hand-computed values.
        chk("model_sra4",  ref_alu(4'd8, 32'h80000010, 32'd4), 32'hF8000001);
        chk("model_sra32", ref_alu(4'd8, 32'h80000010, 32'd32), 32'hFFFFFFFF);
        chk("model_sra33", ref_alu(4'd8, 32'h7FFFFFFF, 32'd33), 32'h00000000);
        chk("model_sll40", ref_alu(4'd6, 32'hFFFFFFFF, 32'd40), 32'h00000000);
        chk("model_mul",   ref_alu(4'd11, 32'h00010003, 32'h00010005), 32'h0008000F);
        chk("model_slt",   ref_alu(4'd9, 32'hFFFFFFFF, 32'd1), 32'd1);
        chk("model_sltu",  ref_alu(4'd10, 32'hFFFFFFFF, 32'd1), 32'd0);
        chk("model_sub",   ref_alu(4'd1, 32'd3, 32'd5), 32'hFFFFFFFE);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", in_ready, 1);
        step();

        // Shift bounds and illegal / compare ops.
        send1("sra_b4",  4'd8, 32'h80000010, 32'd4,  32'hF8000001, 1'b0, 1'b0);
        send1("sra_b32", 4'd8, 32'h80000010, 32'd32, 32'hFFFFFFFF, 1'b0, 1'b0);
        send1("sra_b33", 4'd8, 32'h7FFFFFFF, 32'd33, 32'h00000000, 1'b1, 1'b0);
        send1("sll_b32", 4'd6, 32'hFFFFFFFF, 32'd32, 32'h00000000, 1'b1, 1'b0);
        send1("srl_b31", 4'd7, 32'h80000000, 32'd31, 32'h00000001, 1'b0, 1'b0);
        send1("illegal13", 4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1);
        send1("slt_m1_1",  4'd9,  32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        send1("sltu_max_1", 4'd10, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);

        // MUL timing: busy for 32 cycles, result visible after edge k+32.
        in_valid = 1'b1;
        op       = 4'd11;
        A        = 32'h00010003;
        B        = 32'h00010005;
        step();
        in_valid = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) n_bad++;
            step();
        end
        chk("mul_busy_cycles_ready_or_valid", n_bad, 0);
        chk("mul_out_valid", out_valid, 1);
        chk("mul_result", result, 32'h0008000F);
        step();

        // Backpressure then same-edge handoff.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 4'd0;
        A         = 32'd5;
        B         = 32'd7;
        step();
        in_valid = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (result !== 32'd12 || out_valid !== 1'b1 || in_ready !== 1'b0) n_bad++;
            step();
        end
        chk("bp_hold_errors", n_bad, 0);
        in_valid  = 1'b1;
        op        = 4'd1;
        A         = 32'd3;
        B         = 32'd5;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_handoff_valid", out_valid, 1);
        chk("bp_handoff_result", result, 32'hFFFFFFFE);

        // Streaming: 8 back-to-back single-cycle ops.
        n_bad = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op       = 4'($urandom_range(0, 10));
            A        = $urandom;
            B        = $urandom_range(0, 40);
            exp_stream[i] = ref_alu(op, A, B);
            step();
            if (out_valid !== 1'b1) n_bad++;
            chk("stream_result", result, exp_stream[i]);
        end
        in_valid = 1'b0;
        chk("stream_bubbles", n_bad, 0);
        step();

        // Asynchronous reset in the middle of a MUL.
        in_valid = 1'b1;
        op       = 4'd11;
        A        = $urandom;
        B        = $urandom;
        step();
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midmul_rst_out_valid", out_valid, 0);
        chk("midmul_rst_result", result, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("midmul_release_in_ready", in_ready, 1);
        n_bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0) n_bad++;
        end
        chk("midmul_no_result", n_bad, 0);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            op        = 4'($urandom_range(0, 15));
            A         = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            B         = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 9) == 0) B = A;
            out_ready = ($urandom_range(0, 99) < 75);
            step();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
